receiver_control_unit: RTL and testbench

FSM that sequences UART frame reception alongside receiver_datapath. It synchronises the raw RX pin and detects the start bit. It drives the START/DATA/STOP state flags that enable the datapath counters and shifter. It consumes the datapath's sample-point and last-bit indications and reports a completed byte, a framing error, or a line break.

---
 rtl/receiver_control_unit.sv | 96 +++++++++
 tb/tb_receiver_control_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/receiver_control_unit.sv
// UART receive sequencer: synchronises RX, tracks START/DATA/STOP/BREAK and
// reports completed bytes, framing errors and line breaks to the datapath side.
module receiver_control_unit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clock,
  input  logic i_resetL,
  input  logic i_RX,
  input  logic i_equal,
  input  logic i_equal_MSB,
  output logic o_RX_sync,
  output logic o_state_is_START,
  output logic o_state_is_DATA,
  output logic o_state_is_STOP,
  output logic o_data_valid,
  output logic o_framing_error,
  output logic o_break,
  output logic o_busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   data_valid_q, data_valid_d;
  logic                   framing_error_q, framing_error_d;

  // Synchroniser resets to all ones so an idle-high line never looks like a start bit.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_RX};
  end

  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) begin
      sync_q          <= '1;
      state_q         <= ST_IDLE;
      data_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      sync_q          <= sync_d;
      state_q         <= state_d;
      data_valid_q    <= data_valid_d;
      framing_error_q <= framing_error_d;
    end
  end

  assign o_RX_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d         = state_q;
    data_valid_d    = 1'b0;
    framing_error_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!o_RX_sync) state_d = ST_START;
      end
      ST_START: begin
        // A start bit that is high again at its sample point was a glitch.
        if (i_equal) state_d = o_RX_sync ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (i_equal && i_equal_MSB) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (i_equal) begin
          if (o_RX_sync) begin
            state_d      = ST_IDLE;
            data_valid_d = 1'b1;
          end else begin
            state_d         = ST_BREAK;
            framing_error_d = 1'b1;
          end
        end
      end
      ST_BREAK: begin
        if (o_RX_sync) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_state_is_START = (state_q == ST_START);
  assign o_state_is_DATA  = (state_q == ST_DATA);
  assign o_state_is_STOP  = (state_q == ST_STOP);
  assign o_break          = (state_q == ST_BREAK);
  assign o_busy           = (state_q != ST_IDLE);
  assign o_data_valid     = data_valid_q;
  assign o_framing_error  = framing_error_q;

endmodule

// File: tb/tb_receiver_control_unit.sv
// Directed bench for receiver_control_unit; completion pulses are checked by a
// scoreboard monitor, state flags by in-line checks at hand-computed cycles.
module tb_receiver_control_unit;

  localparam int BIT_CYCLES = 16;
  localparam int SAMPLE_AT  = 8;

  logic i_clock = 1'b0;
  logic i_resetL;
  logic i_RX;
  logic i_equal;
  logic i_equal_MSB;
  logic o_RX_sync;
  logic o_state_is_START;
  logic o_state_is_DATA;
  logic o_state_is_STOP;
  logic o_data_valid;
  logic o_framing_error;
  logic o_break;
  logic o_busy;

  int compare_count  = 0;
  int mismatch_count = 0;

  // Expected completion pulses: 2'b10 = data_valid, 2'b01 = framing_error.
  logic [1:0] exp_queue[$];

  receiver_control_unit #(.SYNC_STAGES(2)) dut (
    .i_clock          (i_clock),
    .i_resetL         (i_resetL),
    .i_RX             (i_RX),
    .i_equal          (i_equal),
    .i_equal_MSB      (i_equal_MSB),
    .o_RX_sync        (o_RX_sync),
    .o_state_is_START (o_state_is_START),
    .o_state_is_DATA  (o_state_is_DATA),
    .o_state_is_STOP  (o_state_is_STOP),
    .o_data_valid     (o_data_valid),
    .o_framing_error  (o_framing_error),
    .o_break          (o_break),
    .o_busy           (o_busy)
  );

  always #5 i_clock = ~i_clock;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    compare_count++;
    if (actual !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rx, input logic eq, input logic msb);
    i_RX        = rx;
    i_equal     = eq;
    i_equal_MSB = msb;
  endtask

  function automatic logic [7:0] out_vec();
    return {o_RX_sync, o_state_is_START, o_state_is_DATA, o_state_is_STOP,
            o_break, o_busy, o_data_valid, o_framing_error};
  endfunction

  // Monitor: every completion pulse must match the next scoreboard entry.
  always @(negedge i_clock) begin
    if (i_resetL === 1'b1 && (o_data_valid === 1'b1 || o_framing_error === 1'b1)) begin
      if (exp_queue.size() == 0) begin
        checkOutput("unexpected_pulse", {6'd0, o_data_valid, o_framing_error}, 8'h00);
      end else begin
        checkOutput("completion_pulse", {6'd0, o_data_valid, o_framing_error},
                    {6'd0, exp_queue.pop_front()});
      end
    end
  end

  // Frame: bit 0 = start, 1..8 = data LSB first, 9 = stop. abort_bit < 10 resets mid-frame.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int abort_bit);
    logic rx;
    if (abort_bit > 9) exp_queue.push_back(stop_bit ? 2'b10 : 2'b01);
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < BIT_CYCLES; c++) begin
        @(negedge i_clock);
        if (b == abort_bit && c == 0) begin
          i_resetL = 1'b0;
          #1;
          checkOutput("reset_midframe_async", out_vec(), 8'h80);
          applyStimulus(1'b1, 1'b0, 1'b0);
          repeat (3) @(negedge i_clock);
          i_resetL = 1'b1;
          return;
        end
        if (b == 0 && c == 2) checkOutput("start_not_yet", {7'd0, o_state_is_START}, 8'h00);
        if (b == 0 && c == 3) checkOutput("start_entry", {6'd0, o_state_is_START, o_busy}, 8'h03);
        if (b == 1 && c == 4) checkOutput("data_state", {5'd0, o_state_is_START, o_state_is_DATA, o_state_is_STOP}, 8'h02);
        if (b == 9 && c == 4) checkOutput("stop_state", {5'd0, o_state_is_START, o_state_is_DATA, o_state_is_STOP}, 8'h01);
        if (b == 9 && c == 10)
          checkOutput("after_stop", {5'd0, o_state_is_STOP, o_break, o_busy},
                      stop_bit ? 8'h00 : 8'h03);
        case (b)
          0:       rx = 1'b0;
          9:       rx = stop_bit;
          default: rx = data[b-1];
        endcase
        applyStimulus(rx, (c == SAMPLE_AT), (b == 8));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_resetL = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge i_clock);
    checkOutput("reset_state", out_vec(), 8'h80);
    i_resetL = 1'b1;

    // Idle: stray i_equal/i_equal_MSB must be ignored.
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clock);
      checkOutput("idle_hold", out_vec(), 8'h80);
      applyStimulus(1'b1, (i % 17 == 5), (i % 23 == 7));
    end
    applyStimulus(1'b1, 1'b0, 1'b0);

    // Glitch: low for 3 cycles, sample point 20 cycles later sees high.
    for (int i = 0; i < 30; i++) begin
      @(negedge i_clock);
      if (i == 3) checkOutput("glitch_start", {7'd0, o_state_is_START}, 8'h01);
      if (i == 20) checkOutput("glitch_still_start", {7'd0, o_state_is_START}, 8'h01);
      if (i == 21 || i == 28) checkOutput("glitch_rejected", out_vec(), 8'h80);
      applyStimulus((i >= 3), (i == 20), 1'b0);
    end

    send_frame(8'hA5, 1'b1, 99);
    repeat (10) @(negedge i_clock);
    checkOutput("good_frame_idle", out_vec(), 8'h80);

    // Framing error followed by a held-low line.
    send_frame(8'hA5, 1'b0, 99);
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (200) @(negedge i_clock);
    checkOutput("break_held", {6'd0, o_break, o_busy}, 8'h03);
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge i_clock);
    checkOutput("break_rise_1", {7'd0, o_break}, 8'h01);
    @(negedge i_clock);
    checkOutput("break_rise_2", {7'd0, o_break}, 8'h01);
    @(negedge i_clock);
    checkOutput("break_cleared", out_vec(), 8'h80);
    repeat (5) @(negedge i_clock);

    // Back-to-back: second start bit directly after the first stop bit.
    send_frame(8'h3C, 1'b1, 99);
    send_frame(8'hC3, 1'b1, 99);
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (10) @(negedge i_clock);

    // Reset asserted during data bit 3.
    send_frame(8'h5A, 1'b1, 4);
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clock);
      if (i == 2 || i == 19) checkOutput("post_reset_idle", out_vec(), 8'h80);
    end

    checkOutput("scoreboard_drained", exp_queue.size(), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
